// File: rtl/sprite_line_buffer.sv
// Double-banked 256x8 sprite line buffer: the sprite engine fills the back bank while the
// front bank is scanned out and cleared behind the beam; banks swap on each HBLANK_n rise.
module sprite_line_buffer (
  input  logic       i_EMU_MCLK,
  input  logic       i_MRST_n,
  input  logic       i_EMU_CLK6MPCEN_n,
  input  logic       i_HBLANK_n,
  input  logic [7:0] i_RD_ADDR,
  input  logic       i_WR_EN,
  input  logic [7:0] i_WR_ADDR,
  input  logic [7:0] i_WR_DATA,
  input  logic       i_WR_FORCE,
  output logic [7:0] o_PIXEL,
  output logic       o_BANK,
  output logic       o_INIT_BUSY
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [7:0] mem0_q [0:255];
  logic [7:0] mem1_q [0:255];

  logic [0:0] state_q, state_d;
  logic [7:0] clr_addr_q, clr_addr_d;
  logic       hb_prev_q, hb_prev_d;
  logic       bank_q, bank_d;
  logic [7:0] pixel_q, pixel_d;

  logic       en, run;
  logic [7:0] front_rd, back_old;
  logic       wr_ok, rd_clr;
  logic       we0, we1;
  logic [7:0] a0, a1, d0, d1;

  assign en  = ~i_EMU_CLK6MPCEN_n;
  assign run = (state_q == ST_RUN);

  // Front and back are chosen by the pre-toggle bank, so a swap cycle still
  // reads the outgoing line and writes into the incoming one.
  assign front_rd = bank_q ? mem1_q[i_RD_ADDR] : mem0_q[i_RD_ADDR];
  assign back_old = bank_q ? mem0_q[i_WR_ADDR] : mem1_q[i_WR_ADDR];

  assign wr_ok  = run & en & i_WR_EN & (i_WR_DATA[3:0] != 4'd0) &
                  (i_WR_FORCE | (back_old[3:0] == 4'd0));
  assign rd_clr = run & en & i_HBLANK_n;

  always_comb begin
    we0 = 1'b0;
    we1 = 1'b0;
    a0  = 8'd0;
    a1  = 8'd0;
    d0  = 8'd0;
    d1  = 8'd0;
    if (!run && en) begin
      we0 = 1'b1;
      we1 = 1'b1;
      a0  = clr_addr_q;
      a1  = clr_addr_q;
    end else begin
      if (rd_clr) begin
        if (bank_q) begin
          we1 = 1'b1;
          a1  = i_RD_ADDR;
        end else begin
          we0 = 1'b1;
          a0  = i_RD_ADDR;
        end
      end
      // Read-clear and sprite write always target opposite banks.
      if (wr_ok) begin
        if (bank_q) begin
          we0 = 1'b1;
          a0  = i_WR_ADDR;
          d0  = i_WR_DATA;
        end else begin
          we1 = 1'b1;
          a1  = i_WR_ADDR;
          d1  = i_WR_DATA;
        end
      end
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (we0) mem0_q[a0] <= d0;
    if (we1) mem1_q[a1] <= d1;
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    hb_prev_d  = hb_prev_q;
    bank_d     = bank_q;
    pixel_d    = pixel_q;
    if (en) begin
      hb_prev_d = i_HBLANK_n;
      if (!run) begin
        clr_addr_d = clr_addr_q + 8'd1;
        pixel_d    = 8'd0;
        if (clr_addr_q == 8'hFF) state_d = ST_RUN;
      end else begin
        pixel_d = i_HBLANK_n ? front_rd : 8'd0;
        if (i_HBLANK_n && !hb_prev_q) bank_d = ~bank_q;
      end
    end
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_q    <= ST_INIT;
      clr_addr_q <= 8'd0;
      hb_prev_q  <= 1'b0;
      bank_q     <= 1'b0;
      pixel_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      hb_prev_q  <= hb_prev_d;
      bank_q     <= bank_d;
      pixel_q    <= pixel_d;
    end
  end

  assign o_PIXEL     = pixel_q;
  assign o_BANK      = bank_q;
  assign o_INIT_BUSY = ~run;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed bench for sprite_line_buffer: expected pixels are queued as each cycle is
// driven and popped when the registered output appears one enabled cycle later.
module tb_sprite_line_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen_n;
  logic       hb;
  logic [7:0] rd;
  logic       we;
  logic [7:0] wa;
  logic [7:0] wd;
  logic       wf;
  logic [7:0] o_pixel;
  logic       o_bank;
  logic       o_busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q [$];

  sprite_line_buffer dut (
    .i_EMU_MCLK       (clk),
    .i_MRST_n         (rst_n),
    .i_EMU_CLK6MPCEN_n(cen_n),
    .i_HBLANK_n       (hb),
    .i_RD_ADDR        (rd),
    .i_WR_EN          (we),
    .i_WR_ADDR        (wa),
    .i_WR_DATA        (wd),
    .i_WR_FORCE       (wf),
    .o_PIXEL          (o_pixel),
    .o_BANK           (o_bank),
    .o_INIT_BUSY      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled cycle: drive, queue the expected pixel, then compare after the edge.
  task automatic cyc(input string tag, input logic h, input logic [7:0] ra, input logic w,
                     input logic [7:0] a, input logic [7:0] d, input logic f,
                     input logic [7:0] exp);
    hb = h; rd = ra; we = w; wa = a; wd = d; wf = f;
    sb_q.push_back(exp);
    tick();
    chk(tag, {24'd0, o_pixel}, {24'd0, sb_q.pop_front()});
    we = 1'b0; wf = 1'b0;
  endtask

  task automatic init_count(input string tag, input logic noisy);
    int n;
    logic pix_bad;
    logic bank_bad;
    n = 0; pix_bad = 1'b0; bank_bad = 1'b0;
    while (o_busy && n < 300) begin
      if (noisy) begin
        hb = n[0]; we = 1'b1; wa = 8'h05; wd = 8'h11; wf = 1'b1; rd = 8'h05;
      end
      tick();
      n++;
      if (o_pixel !== 8'h00) pix_bad = 1'b1;
      if (o_bank !== 1'b0) bank_bad = 1'b1;
    end
    we = 1'b0; wf = 1'b0; hb = 1'b0;
    chk({tag, "_len"}, n, 256);
    chk({tag, "_pix0"}, {31'd0, pix_bad}, 0);
    chk({tag, "_bank0"}, {31'd0, bank_bad}, 0);
  endtask

  initial begin
    rst_n = 1'b0; cen_n = 1'b0; hb = 1'b0; rd = 8'h00;
    we = 1'b0; wa = 8'h00; wd = 8'h00; wf = 1'b0;
    #12;
    chk("rst_pix", {24'd0, o_pixel}, 0);
    chk("rst_bank", {31'd0, o_bank}, 0);
    chk("rst_busy", {31'd0, o_busy}, 1);
    tick();
    rst_n = 1'b1;

    // Post-reset clear with HBLANK toggling and forced writes that must be ignored.
    init_count("init", 1'b1);
    cyc("blank0", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 257; i++) cyc("zero_l1", 1'b1, 8'(i), 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("bank_l1", {31'd0, o_bank}, 1);
    cyc("blank1", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 257; i++) cyc("zero_l2", 1'b1, 8'(i), 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("bank_l2", {31'd0, o_bank}, 0);

    // Basic write, swap, read, clear-after-read.
    cyc("blank2", 1'b0, 8'h40, 1'b1, 8'h40, 8'h35, 1'b0, 8'h00);
    cyc("swap3", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("bank_l3", {31'd0, o_bank}, 1);
    cyc("rd40", 1'b1, 8'h40, 1'b0, 8'h00, 8'h00, 1'b0, 8'h35);
    cyc("rd40_clr", 1'b1, 8'h40, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

    // Priority and transparency into back bank 0.
    cyc("w20a", 1'b0, 8'h00, 1'b1, 8'h20, 8'h12, 1'b0, 8'h00);
    cyc("w20b", 1'b0, 8'h00, 1'b1, 8'h20, 8'h47, 1'b0, 8'h00);
    cyc("w21a", 1'b0, 8'h00, 1'b1, 8'h21, 8'h12, 1'b0, 8'h00);
    cyc("w21b", 1'b0, 8'h00, 1'b1, 8'h21, 8'h47, 1'b1, 8'h00);
    cyc("w22a", 1'b0, 8'h00, 1'b1, 8'h22, 8'h33, 1'b0, 8'h00);
    cyc("w22b", 1'b0, 8'h00, 1'b1, 8'h22, 8'h50, 1'b1, 8'h00);
    cyc("w23", 1'b0, 8'h00, 1'b1, 8'h23, 8'h60, 1'b1, 8'h00);
    cyc("wff", 1'b0, 8'h00, 1'b1, 8'hFF, 8'h9A, 1'b0, 8'h00);
    cyc("swap4", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("bank_l4", {31'd0, o_bank}, 0);
    cyc("rd20", 1'b1, 8'h20, 1'b1, 8'h30, 8'h77, 1'b0, 8'h12);
    cyc("rd21", 1'b1, 8'h21, 1'b0, 8'h00, 8'h00, 1'b0, 8'h47);
    cyc("rd22", 1'b1, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0, 8'h33);
    cyc("rd23", 1'b1, 8'h23, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    cyc("rdff", 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 8'h9A);

    // Clock enable held off across an HBLANK rise with a write pending.
    cyc("blank5", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    cen_n = 1'b1; hb = 1'b1; rd = 8'h30; we = 1'b1; wa = 8'h50; wd = 8'h2A; wf = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_pix", {24'd0, o_pixel}, 0);
      chk("hold_bank", {31'd0, o_bank}, 0);
    end
    cen_n = 1'b0; we = 1'b0; wf = 1'b0;
    cyc("blank6", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    cyc("swap6", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("bank_l6", {31'd0, o_bank}, 1);
    cyc("rd30", 1'b1, 8'h30, 1'b0, 8'h00, 8'h00, 1'b0, 8'h77);
    cyc("rd50", 1'b1, 8'h50, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

    // Write on the exact swap cycle lands in the incoming front bank.
    cyc("blank7", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    cyc("swap7", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("bank_l7", {31'd0, o_bank}, 0);
    cyc("blank8", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    cyc("swap8w", 1'b1, 8'h00, 1'b1, 8'h10, 8'h5C, 1'b0, 8'h00);
    chk("bank_l8", {31'd0, o_bank}, 1);
    cyc("rd10", 1'b1, 8'h10, 1'b1, 8'h66, 8'h3B, 1'b0, 8'h5C);

    // Asynchronous reset mid-line, then again mid-INIT.
    rst_n = 1'b0;
    #1;
    chk("arst_pix", {24'd0, o_pixel}, 0);
    chk("arst_bank", {31'd0, o_bank}, 0);
    chk("arst_busy", {31'd0, o_busy}, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_init_busy", {31'd0, o_busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst2_busy", {31'd0, o_busy}, 1);
    chk("arst2_pix", {24'd0, o_pixel}, 0);
    tick();
    rst_n = 1'b1;
    init_count("reinit", 1'b0);
    cyc("blank9", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    cyc("swap9_rd66", 1'b1, 8'h66, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    chk("bank_l9", {31'd0, o_bank}, 1);
    cyc("rd10_b1", 1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_line_buffer.md
SPRITE_LINE_BUFFER -- requirements
Module: sprite_line_buffer

Interface
REQ-001 SHALL have i_EMU_MCLK, input, 1: master clock; all state changes on its rising edge.
REQ-002 SHALL have i_MRST_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have i_EMU_CLK6MPCEN_n, input, 1: pixel clock enable, active-low; no state except reset changes when it is high.
REQ-004 SHALL have i_HBLANK_n, input, 1: horizontal blank from the timing generator; 1 = active display, 0 = blank.
REQ-005 SHALL have i_RD_ADDR, input, 8: scan-out pixel address, the flip-adjusted H count (FLIP_128H..FLIP_1H).
REQ-006 SHALL have i_WR_EN, input, 1: sprite pixel write request.
REQ-007 SHALL have i_WR_ADDR, input, 8: sprite pixel X position.
REQ-008 SHALL have i_WR_DATA, input, 8: {palette[7:4], colour[3:0]}; colour 0 = transparent.
REQ-009 SHALL have i_WR_FORCE, input, 1: overwrite regardless of existing pixel.
REQ-010 SHALL have o_PIXEL, output, 8: registered sprite pixel for the mixer.
REQ-011 SHALL have o_BANK, output, 1: index of the current front (display) bank.
REQ-012 SHALL have o_INIT_BUSY, output, 1: high while post-reset clear runs.

Function
REQ-013 SHALL hold two 256x8 banks; front = bank o_BANK (read/clear), back = bank ~o_BANK (write).
REQ-014 SHALL have FSM states INIT and RUN; reset enters INIT with clear address 0.
REQ-015 In INIT, each enabled cycle SHALL write 0 to address clr_addr of both banks and increment clr_addr (8-bit).
REQ-016 SHALL transition INIT -> RUN on the enabled cycle that clears address 255 (256 enabled cycles); o_INIT_BUSY = 1 only in INIT.
REQ-017 In INIT, write requests SHALL be ignored, o_PIXEL SHALL be 0, and bank swap SHALL not occur.
REQ-018 SHALL register i_HBLANK_n into hb_prev on every enabled cycle, in both states.
REQ-019 In RUN, rising edge of HBLANK_n (hb_prev=0, i_HBLANK_n=1) on an enabled cycle SHALL toggle o_BANK, effective the next cycle.
REQ-020 In RUN with i_HBLANK_n=1, each enabled cycle SHALL load o_PIXEL <= front[i_RD_ADDR] and write front[i_RD_ADDR] <= 0 (clear-after-read); read latency 1 enabled cycle.
REQ-021 In RUN with i_HBLANK_n=0, each enabled cycle SHALL load o_PIXEL <= 0 with no front clear.
REQ-022 On the swap cycle, read/clear and write SHALL use the pre-toggle o_BANK.
REQ-023 In RUN, an enabled cycle with i_WR_EN=1 SHALL write back[i_WR_ADDR] <= i_WR_DATA iff i_WR_DATA[3:0]!=0 and (i_WR_FORCE=1 or back[i_WR_ADDR][3:0]==0).
REQ-024 Transparent writes (colour 0) SHALL never modify the buffer, even with i_WR_FORCE=1.
REQ-025 Writes SHALL be accepted in both blank and active periods; write address 255 -> 0 has no wrap semantics (8-bit, no overflow).
REQ-026 Read clear and write never collide (different banks); no arbitration required.
REQ-027 With i_EMU_CLK6MPCEN_n=1, all registers and memory SHALL hold.

Reset
REQ-028 Assertion of i_MRST_n=0 SHALL immediately force o_PIXEL=0, o_BANK=0, hb_prev=0, FSM=INIT, clr_addr=0, o_INIT_BUSY=1, including mid-line or mid-INIT.
REQ-029 Memory contents SHALL NOT be reset asynchronously; INIT clear SHALL guarantee all-zero banks before RUN.
REQ-030 Release SHALL take effect on the first rising edge with i_MRST_n=1; a new INIT sequence always runs in full.

Verification
REQ-031 Reset release, enable every cycle -> o_INIT_BUSY=1 for exactly 256 enabled cycles, then 0; o_PIXEL=0 throughout; full read of both banks returns 0.
REQ-032 RUN, HBLANK_n=0, write addr 0x40 data 0x35; HBLANK_n rises -> o_BANK 0->1; when i_RD_ADDR=0x40, o_PIXEL=0x35 one enabled cycle later; reading 0x40 on the next line returns 0x00.
REQ-033 Write 0x12 then 0x47 to same addr (no force) -> readback 0x12; repeat with second write i_WR_FORCE=1 -> 0x47; write 0x50 with force -> location unchanged.
REQ-034 Toggle i_EMU_CLK6MPCEN_n=1 for 10 cycles mid-line with HBLANK_n edge and write request present -> no change to o_PIXEL, o_BANK, memory.
REQ-035 Write issued on the exact swap cycle to addr 0x10 with o_BANK=0 -> data lands in bank 1 (now front); visible on the current line.
REQ-036 Assert reset at clr_addr=100 and again mid-active-line in RUN -> outputs to reset values asynchronously; INIT restarts at 0 and completes after 256 enabled cycles.
